// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Bridges a core-side load/store request/response handshake onto a simple
//   single-cycle data memory.  One request is in flight at a time; each is
//   latched on acceptance, range-checked against MEM_DEPTH, then either
//   performs one memory access cycle or goes straight to an error response.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_write          1 = store, 0 = load
//   req_addr           word address (ADDR_W bits)
//   req_wdata          store data
//   rsp_valid/ready    response handshake
//   rsp_rdata          load data (0 for stores and errors)
//   rsp_error          address was out of range
//   mem_address        address to data memory
//   mem_input_data     write data to data memory
//   mem_enable_read    data memory read enable
//   mem_enable_write   data memory write enable
//   mem_read_data      combinational read data from data memory
//   busy               unit is not idle
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_W    = 6,
   parameter int MEM_DEPTH = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_input_data,
   output logic              mem_enable_read,
   output logic              mem_enable_write,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   // One extra bit so a MEM_DEPTH equal to 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

   state_t state;
   logic   lat_write;
   logic   en_read_q;
   logic   en_write_q;
   logic   addr_legal;

   assign addr_legal = ({1'b0, req_addr} < DEPTH_LIMIT);

   // The enables are registered, but reset gates them combinationally so a
   // reset arriving during the access cycle suppresses the memory write.
   assign mem_enable_read  = en_read_q  & ~reset;
   assign mem_enable_write = en_write_q & ~reset;
   assign req_ready        = (state == IDLE) & ~reset;
   assign busy             = (state != IDLE);

   // Request is latched into mem_address / mem_input_data at acceptance, so
   // later changes on req_* cannot disturb the access in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         lat_write      <= 1'b0;
         en_read_q      <= 1'b0;
         en_write_q     <= 1'b0;
         mem_address    <= '0;
         mem_input_data <= '0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_error      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  if (addr_legal) begin
                     state          <= ACCESS;
                     mem_address    <= req_addr;
                     mem_input_data <= req_write ? req_wdata : '0;
                     en_write_q     <= req_write;
                     en_read_q      <= ~req_write;
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_error <= 1'b1;
                     rsp_rdata <= '0;
                  end
               end
            end
            ACCESS: begin
               state          <= RESP;
               en_read_q      <= 1'b0;
               en_write_q     <= 1'b0;
               mem_input_data <= '0;
               rsp_valid      <= 1'b1;
               rsp_error      <= 1'b0;
               rsp_rdata      <= lat_write ? '0 : mem_read_data;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_error <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Purpose:
//   Self-checking bench for mem_access_unit.  Holds a behavioural data memory
//   for the DUT to talk to, and a transaction-level reference model that
//   tracks the single outstanding request by its age since acceptance.  A
//   compare process checks the DUT against the model on every falling edge;
//   directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int ADDR_W    = 6;
   localparam int MEM_DEPTH = 32;
   localparam int DATA_W    = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_error;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_input_data;
   logic              mem_enable_read;
   logic              mem_enable_write;
   logic [DATA_W-1:0] mem_read_data;
   logic              busy;

   int compared = 0;
   int mismatched = 0;
   int cycle_count = 0;
   bit check_en = 1'b0;

   // Data memory seen by the DUT, and the golden copy owned by the model.
   logic [DATA_W-1:0] mem_array [MEM_DEPTH];
   logic [DATA_W-1:0] ref_mem   [MEM_DEPTH];

   // Reference model: one outstanding request, tracked by age in cycles.
   bit                m_busy = 1'b0;
   int                m_age = 0;
   logic [ADDR_W-1:0] m_addr = '0;
   bit                m_write = 1'b0;
   logic [DATA_W-1:0] m_data = '0;
   bit                m_legal = 1'b1;
   logic [DATA_W-1:0] m_rdata = '0;
   bit                m_just_reset = 1'b0;

   mem_access_unit #(
      .ADDR_W   (ADDR_W),
      .MEM_DEPTH(MEM_DEPTH),
      .DATA_W   (DATA_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_rdata       (rsp_rdata),
      .rsp_error       (rsp_error),
      .mem_address     (mem_address),
      .mem_input_data  (mem_input_data),
      .mem_enable_read (mem_enable_read),
      .mem_enable_write(mem_enable_write),
      .mem_read_data   (mem_read_data),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   // Behavioural data memory: combinational read, write on the rising edge.
   assign mem_read_data = (int'(mem_address) < MEM_DEPTH) ? mem_array[int'(mem_address)] : '0;

   always @(posedge clk) begin
      if (mem_enable_write && int'(mem_address) < MEM_DEPTH)
         mem_array[int'(mem_address)] <= mem_input_data;
   end

   // A legal request touches memory on the cycle after acceptance and
   // responds from then on; an illegal one responds immediately.
   function automatic bit respVisible();
      return m_busy && (!m_legal || m_age >= 1);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_busy       = 1'b0;
         m_just_reset = 1'b1;
         m_rdata      = '0;
      end else begin
         m_just_reset = 1'b0;
         if (m_busy) begin
            if (m_legal && m_age == 0) begin
               if (m_write) ref_mem[int'(m_addr)] = m_data;
               else         m_rdata = ref_mem[int'(m_addr)];
            end
            if (respVisible() && rsp_ready) m_busy = 1'b0;
            else                            m_age  = m_age + 1;
         end else if (req_valid) begin
            m_busy  = 1'b1;
            m_age   = 0;
            m_addr  = req_addr;
            m_write = req_write;
            m_data  = req_wdata;
            m_legal = int'(req_addr) < MEM_DEPTH;
            m_rdata = '0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                  name, actual, expected, cycle_count);
      end
   endtask

   // Per-cycle comparison against the reference model.
   always @(negedge clk) begin
      if (check_en) begin
         bit active;
         active = m_busy && m_legal && m_age == 0 && !reset;
         checkOutput("busy", 32'(busy), 32'(m_busy));
         checkOutput("req_ready", 32'(req_ready), 32'(!m_busy && !reset));
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(respVisible()));
         checkOutput("mem_enable_write", 32'(mem_enable_write), 32'(active && m_write));
         checkOutput("mem_enable_read", 32'(mem_enable_read), 32'(active && !m_write));
         if (respVisible()) begin
            checkOutput("rsp_rdata", rsp_rdata, m_rdata);
            checkOutput("rsp_error", 32'(rsp_error), 32'(!m_legal));
         end
         if (active) begin
            checkOutput("mem_address", 32'(mem_address), 32'(m_addr));
            checkOutput("mem_input_data", mem_input_data, m_write ? m_data : '0);
         end
         if (m_just_reset) begin
            checkOutput("rst_rsp_rdata", rsp_rdata, '0);
            checkOutput("rst_rsp_error", 32'(rsp_error), 0);
            checkOutput("rst_mem_address", 32'(mem_address), 0);
            checkOutput("rst_mem_input_data", mem_input_data, '0);
         end
      end
   end

   task automatic applyStimulus(input bit valid, input bit write, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input bit rready, input bit rst);
      #1;
      req_valid = valid;
      req_write = write;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = rready;
      reset     = rst;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [DATA_W-1:0] prior7;
   int  accept_cyc [3];
   bit  seen;
   logic [ADDR_W-1:0] bad_addr [2];

   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
         logic [DATA_W-1:0] v;
         v = $urandom;
         mem_array[i] = v;
         ref_mem[i]   = v;
      end
      prior7 = mem_array[7];
      bad_addr[0] = 6'd32;
      bad_addr[1] = 6'd63;

      // Reset state
      applyStimulus(0, 0, '0, '0, 0, 1);
      stepCycle();
      stepCycle();
      check_en = 1'b1;
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_req_ready_in_reset", 32'(req_ready), 0);
      applyStimulus(0, 0, '0, '0, 0, 0);
      #1;
      checkOutput("reset_req_ready_released", 32'(req_ready), 1);
      stepCycle();

      // Store 0xA5 to address 5
      applyStimulus(1, 1, 6'd5, 32'hA5, 1, 0);
      stepCycle();
      checkOutput("st5_wen", 32'(mem_enable_write), 1);
      checkOutput("st5_addr", 32'(mem_address), 5);
      checkOutput("st5_rsp_valid_early", 32'(rsp_valid), 0);
      applyStimulus(0, 0, '0, '0, 1, 0);
      stepCycle();
      checkOutput("st5_wen_once", 32'(mem_enable_write), 0);
      checkOutput("st5_rsp_valid", 32'(rsp_valid), 1);
      checkOutput("st5_rsp_error", 32'(rsp_error), 0);
      checkOutput("st5_rsp_rdata", rsp_rdata, 0);
      checkOutput("st5_mem", mem_array[5], 32'hA5);
      stepCycle();
      checkOutput("st5_idle", 32'(busy), 0);

      // Load address 5
      applyStimulus(1, 0, 6'd5, 32'hFFFF, 1, 0);
      stepCycle();
      checkOutput("ld5_ren", 32'(mem_enable_read), 1);
      applyStimulus(0, 0, '0, '0, 1, 0);
      stepCycle();
      checkOutput("ld5_rdata", rsp_rdata, 32'hA5);
      checkOutput("ld5_error", 32'(rsp_error), 0);
      stepCycle();

      // Out-of-range loads respond with an error on the next cycle
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1, 0, bad_addr[k], '0, 1, 0);
         stepCycle();
         checkOutput("bad_rsp_valid", 32'(rsp_valid), 1);
         checkOutput("bad_rsp_error", 32'(rsp_error), 1);
         checkOutput("bad_rsp_rdata", rsp_rdata, 0);
         checkOutput("bad_no_enable", 32'(mem_enable_read | mem_enable_write), 0);
         applyStimulus(0, 0, '0, '0, 1, 0);
         stepCycle();
         checkOutput("bad_idle", 32'(busy), 0);
      end
      applyStimulus(1, 0, 6'd31, '0, 1, 0);
      stepCycle();
      checkOutput("ld31_ren", 32'(mem_enable_read), 1);
      applyStimulus(0, 0, '0, '0, 1, 0);
      stepCycle();
      checkOutput("ld31_error", 32'(rsp_error), 0);
      checkOutput("ld31_rdata", rsp_rdata, ref_mem[31]);
      stepCycle();

      // Response held by back-pressure while a new request waits
      applyStimulus(1, 0, 6'd5, '0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, 6'd9, 32'h1234, 0, 0);
      for (int k = 0; k < 4; k++) begin
         stepCycle();
         checkOutput("hold_rsp_valid", 32'(rsp_valid), 1);
         checkOutput("hold_rsp_rdata", rsp_rdata, 32'hA5);
         checkOutput("hold_req_ready", 32'(req_ready), 0);
      end
      applyStimulus(0, 0, '0, '0, 1, 0);
      stepCycle();
      checkOutput("hold_released_busy", 32'(busy), 0);
      checkOutput("hold_released_valid", 32'(rsp_valid), 0);

      // Reset during the access cycle of a store suppresses the write
      applyStimulus(1, 1, 6'd7, 32'h3C, 1, 0);
      stepCycle();
      checkOutput("st7_wen", 32'(mem_enable_write), 1);
      applyStimulus(0, 0, '0, '0, 1, 1);
      #1;
      checkOutput("st7_wen_gated", 32'(mem_enable_write), 0);
      stepCycle();
      checkOutput("st7_rst_valid", 32'(rsp_valid), 0);
      checkOutput("st7_rst_busy", 32'(busy), 0);
      checkOutput("st7_rst_addr", 32'(mem_address), 0);
      checkOutput("st7_mem_kept", mem_array[7], prior7);
      applyStimulus(0, 0, '0, '0, 1, 0);
      stepCycle();
      applyStimulus(1, 0, 6'd7, '0, 1, 0);
      stepCycle();
      applyStimulus(0, 0, '0, '0, 1, 0);
      stepCycle();
      checkOutput("ld7_prior", rsp_rdata, prior7);
      stepCycle();

      // Back-to-back stores with req_valid held high
      for (int s = 0; s < 3; s++) begin
         applyStimulus(1, 1, 6'(10 + s), 32'(32'h100 + s), 1, 0);
         seen = 1'b0;
         for (int k = 0; k < 10 && !seen; k++) begin
            stepCycle();
            if (mem_enable_write) begin
               seen = 1'b1;
               accept_cyc[s] = cycle_count;
            end
         end
         checkOutput("b2b_accepted", 32'(seen), 1);
      end
      applyStimulus(0, 0, '0, '0, 1, 0);
      checkOutput("b2b_gap1", 32'(accept_cyc[1] - accept_cyc[0]), 3);
      checkOutput("b2b_gap2", 32'(accept_cyc[2] - accept_cyc[1]), 3);
      stepCycle();
      stepCycle();
      checkOutput("b2b_mem12", mem_array[12], 32'h102);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [ADDR_W-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
         applyStimulus($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), a, $urandom,
                       $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
         stepCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 6, width of request and memory address.
REQ-002 Parameter MEM_DEPTH, default 32, number of valid data-memory words; legal addresses are 0..MEM_DEPTH-1.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  core presents a load/store request.
REQ-006 req_ready  out  1  unit accepts a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  ADDR_W  word address.
REQ-009 req_wdata  in  bus_type  store data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  core consumes response.
REQ-012 rsp_rdata  out  bus_type  load data; 0 for stores and errors.
REQ-013 rsp_error  out  1  request address out of range.
REQ-014 mem_address  out  ADDR_W  address to data memory.
REQ-015 mem_input_data  out  bus_type  write data to data memory.
REQ-016 mem_enable_read  out  1  data-memory read enable.
REQ-017 mem_enable_write  out  1  data-memory write enable.
REQ-018 mem_read_data  in  bus_type  combinational read data from data memory.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with reset low; request accepted on an edge where req_valid && req_ready.
REQ-022 On acceptance, unit SHALL latch req_write, req_addr, req_wdata; later changes on req_* SHALL have no effect until the next acceptance.
REQ-023 Accepted request with req_addr < MEM_DEPTH SHALL move IDLE -> ACCESS; with req_addr >= MEM_DEPTH SHALL move IDLE -> RESP with rsp_error=1, rsp_rdata=0, and no memory enable asserted at any point.
REQ-024 ACCESS SHALL last exactly one cycle: mem_address = latched address; store: mem_enable_write=1, mem_input_data = latched wdata; load: mem_enable_read=1, mem_input_data=0.
REQ-025 Load: rsp_rdata SHALL capture mem_read_data at the edge ending ACCESS; store: rsp_rdata=0; rsp_error=0 in both cases; ACCESS -> RESP unconditionally.
REQ-026 mem_enable_read and mem_enable_write SHALL be 0 in IDLE and RESP, never both 1, and forced 0 whenever reset is high.
REQ-027 RESP: rsp_valid=1; rsp_rdata and rsp_error SHALL hold stable until rsp_valid && rsp_ready; that edge SHALL move RESP -> IDLE and clear rsp_valid.
REQ-028 rsp_ready outside RESP SHALL be ignored; rsp_valid SHALL be 0 outside RESP.
REQ-029 Latency, legal address: request accepted at edge E0; memory write committed at E1; rsp_valid high from E1; with rsp_ready held 1, IDLE again after E2; minimum spacing between accepted requests is 3 cycles.
REQ-030 Latency, illegal address: rsp_valid high from E0; with rsp_ready held 1, IDLE again after E1.
REQ-031 Address comparison SHALL be unsigned on the full ADDR_W bits; address MEM_DEPTH-1 is legal, MEM_DEPTH is an error.
REQ-032 No request SHALL be accepted while a response is pending; requests are never dropped, only stalled via req_ready=0.

Reset
REQ-033 An edge with reset=1 SHALL force IDLE from any state, discarding any in-flight request and pending response.
REQ-034 After reset: rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_address=0, mem_input_data=0, mem_enable_read=0, mem_enable_write=0, busy=0; req_ready=1 in the first cycle with reset low.
REQ-035 reset asserted during ACCESS of a store SHALL suppress the write (enable forced 0 that cycle); memory contents at that address remain unchanged.

Verification
REQ-036 Store addr 5 data 0xA5, rsp_ready=1 -> mem_enable_write=1 for exactly one cycle with mem_address=5; rsp_valid one cycle later with rsp_error=0, rsp_rdata=0.
REQ-037 Load addr 5 after REQ-036 -> mem_enable_read=1 one cycle, rsp_rdata=0xA5, rsp_error=0.
REQ-038 Load addr 32 (and 63) -> no memory enable ever asserted, rsp_valid next cycle with rsp_error=1, rsp_rdata=0; addr 31 completes normally.
REQ-039 Load addr 5 with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata=0xA5 stable all 4 cycles, req_ready=0 despite req_valid=1; IDLE one edge after rsp_ready=1.
REQ-040 Store addr 7 data 0x3C with reset=1 during ACCESS -> no write, all outputs at reset values; subsequent load addr 7 returns prior contents.
REQ-041 Back-to-back req_valid held high with 3 stores -> each accepted exactly once, accepts spaced 3 cycles apart, enables never overlap.
